// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the ARM pipeline front end.
//   fetch_state_t : fetch FSM encoding (S_BOOT, S_FETCH, S_WAIT), 2 bits
//   ARM_NOP       : word placed in decode for bubbles and flushes
//   PC_INC        : sequential PC step
package arm_pipe_pkg;

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_FETCH = 2'd1,
      S_WAIT  = 2'd2
   } fetch_state_t;

   localparam logic [31:0] ARM_NOP = 32'h0000_0000;
   localparam logic [31:0] PC_INC  = 32'd4;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage.
//   ImemReq   : fetch side requests the word at ImemAddr
//   ImemAddr  : byte address of the requested word (the current PCF)
//   ImemReady : memory side presents a valid InstrF this cycle
//   InstrF    : fetched word, combinational from ImemAddr
// Handshake: a word transfers in every cycle where ImemReq and ImemReady are
// both high; the memory may hold ImemReady low for any number of wait cycles
// and the requester keeps ImemReq and ImemAddr stable until it sees ImemReady.
// Modports: master = fetch stage, slave = instruction memory.
interface fetch_stage_if;

   logic        ImemReq;
   logic [31:0] ImemAddr;
   logic        ImemReady;
   logic [31:0] InstrF;

   modport master (output ImemReq, output ImemAddr, input ImemReady, input InstrF);
   modport slave  (input ImemReq, input ImemAddr, output ImemReady, output InstrF);

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : load a bubble (highest priority)
//   stall      : hold current contents
//   load       : capture instr_in / pcplus4_in as a valid instruction
//   instr_in   : fetched word
//   pcplus4_in : PC of the fetched word plus 4
//   instr      : decode instruction
//   pcplus4    : PC+4 of the decode instruction
//   valid      : instr is a real instruction
// Anything not flushed, held or loaded becomes a bubble. Bubbles keep the old
// pcplus4 so decode never sees a spurious PC change.
module if_id_reg
   import arm_pipe_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = ARM_NOP
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        stall,
   input  logic        load,
   input  logic [31:0] instr_in,
   input  logic [31:0] pcplus4_in,
   output logic [31:0] instr,
   output logic [31:0] pcplus4,
   output logic        valid
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr   <= NOP_INSTR;
         pcplus4 <= '0;
         valid   <= 1'b0;
      end else if (flush) begin
         instr <= NOP_INSTR;
         valid <= 1'b0;
      end else if (!stall) begin
         if (load) begin
            instr   <= instr_in;
            pcplus4 <= pcplus4_in;
            valid   <= 1'b1;
         end else begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// ARM pipeline fetch stage with IF/ID register.
// Owns PCF and next-PC selection (sequential, E-stage branch, W-stage PC
// write), runs the instruction-memory handshake and feeds decode.
//   clk, reset    : clock, asynchronous active-high reset
//   StallF        : hold PCF (hazard unit)
//   StallD        : hold IF/ID register
//   FlushD        : clear IF/ID register
//   BranchTakenE  : E-stage branch taken, target on ALUResultE
//   PCSrcW        : W-stage write to R15, value on ResultW
//   imem          : instruction-memory port (master side)
//   PCF           : current fetch PC
//   InstrD        : decode instruction
//   PCPlus4D      : PC+4 of the decode instruction
//   ValidD        : InstrD is a real instruction
//   FetchCount    : accepted fetches (zero unless FETCH_PERF_EN)
//   BubbleCount   : bubbles/flushes loaded into IF/ID (zero unless FETCH_PERF_EN)
//   state_dbg     : fetch FSM state
// Build option: `define FETCH_PERF_EN adds saturating performance counters.
module fetch_stage
   import arm_pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = ARM_NOP,
   parameter int          CNT_W     = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               StallF,
   input  logic               StallD,
   input  logic               FlushD,
   input  logic               BranchTakenE,
   input  logic [31:0]        ALUResultE,
   input  logic               PCSrcW,
   input  logic [31:0]        ResultW,
   fetch_stage_if.master      imem,
   output logic [31:0]        PCF,
   output logic [31:0]        InstrD,
   output logic [31:0]        PCPlus4D,
   output logic               ValidD,
   output logic [CNT_W-1:0]   FetchCount,
   output logic [CNT_W-1:0]   BubbleCount,
   output fetch_state_t       state_dbg
);

   fetch_state_t state, state_next;
   logic         redirect;
   logic         accept;
   logic [31:0]  pc_plus4;
   logic [31:0]  pc_next;

   // A redirect discards whatever word arrives this cycle, so it also
   // overrides StallF and any memory wait state.
   assign redirect = BranchTakenE | PCSrcW;
   assign pc_plus4 = PCF + PC_INC;
   assign accept   = imem.ImemReq & imem.ImemReady & ~StallF & ~redirect;

   assign imem.ImemReq  = (state != S_BOOT);
   assign imem.ImemAddr = PCF;
   assign state_dbg     = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_BOOT;
         PCF   <= RESET_PC;
      end else begin
         state <= state_next;
         PCF   <= pc_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_BOOT:  state_next = S_FETCH;
         S_FETCH: if (!imem.ImemReady) state_next = S_WAIT;
         S_WAIT:  if (imem.ImemReady) state_next = S_FETCH;
         default: state_next = S_BOOT;
      endcase
      if (redirect) state_next = S_FETCH;
   end

   always_comb begin
      pc_next = PCF;
      if (BranchTakenE)  pc_next = ALUResultE;
      else if (PCSrcW)   pc_next = ResultW;
      else if (accept)   pc_next = pc_plus4;
   end

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id (
      .clk        (clk),
      .rst        (reset),
      .flush      (FlushD),
      .stall      (StallD),
      .load       (accept),
      .instr_in   (imem.InstrF),
      .pcplus4_in (pc_plus4),
      .instr      (InstrD),
      .pcplus4    (PCPlus4D),
      .valid      (ValidD)
   );

`ifdef FETCH_PERF_EN
   // Mirrors the IF/ID priority: a flush or an unheld non-accept cycle
   // loads a bubble; held cycles count as neither.
   logic bubble_loaded;
   assign bubble_loaded = FlushD | (~StallD & ~accept);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         FetchCount  <= '0;
         BubbleCount <= '0;
      end else begin
         if (accept && (FetchCount != {CNT_W{1'b1}}))
            FetchCount <= FetchCount + {{(CNT_W-1){1'b0}}, 1'b1};
         if (bubble_loaded && (BubbleCount != {CNT_W{1'b1}}))
            BubbleCount <= BubbleCount + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end
`else
   assign FetchCount  = '0;
   assign BubbleCount = '0;
`endif

endmodule
